// File: rtl/cargador_pkg.sv
// -----------------------------------------------------------------------------
// cargador_pkg
// Shared definitions for the byte-stream program loader.
//   state_e    : loader FSM states (ST_CHK only reachable when the
//                CARGADOR_CHECKSUM_EN macro is defined)
//   WORD_BYTES : bytes per instruction word
//   len_max()  : largest legal word count for a given ADDR_WIDTH
// -----------------------------------------------------------------------------
package cargador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int WORD_BYTES = 4;

    // 17 bits so that a 16-bit address space (65536 words) still fits.
    function automatic logic [16:0] len_max(input int addr_width);
        len_max = 17'd1 << addr_width;
    endfunction

endpackage

// File: rtl/cargador_programa_empaquetador_palabra.sv
// -----------------------------------------------------------------------------
// empaquetador_palabra
// Assembles little-endian bytes into a 32-bit word. Byte index 0 lands in
// bits [7:0], index 3 in bits [31:24].
// Ports:
//   clk, srst  : clock and synchronous active-high reset
//   clear      : return the byte index to 0 (word contents are kept)
//   load       : byte_in is written at the current index, index advances
//   byte_in    : incoming byte
//   word       : assembled word
//   word_full  : the byte being loaded this cycle completes the word
// -----------------------------------------------------------------------------
module empaquetador_palabra
    import cargador_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = 2'd0;
        end else if (load) begin
            idx_d = idx_q + 2'd1;  // wraps 3 -> 0 at the word boundary
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            idx_q <= 2'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign word_full = load && !clear && (idx_q == 2'd3);

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_q, lane_d;

            always_comb begin
                lane_d = lane_q;
                if (load && !clear && (idx_q == 2'(gi))) begin
                    lane_d = byte_in;
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    lane_q <= 8'd0;
                end else begin
                    lane_q <= lane_d;
                end
            end

            assign word[gi*8 +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/cargador_programa.sv
// -----------------------------------------------------------------------------
// cargador_programa
// Program loader: receives a length-prefixed little-endian byte stream,
// assembles 32-bit words and writes them into the instruction memory,
// keeping the CPU in reset until a load finishes successfully.
// Optional macro CARGADOR_CHECKSUM_EN: a trailing XOR checksum byte over the
// data bytes is required and verified before DONE.
// Ports:
//   CLK, Reset          : clock, synchronous active-high reset
//   start               : pulse, begins a load from IDLE/DONE/ERR
//   byte_in/byte_valid  : stream input; byte_ready is the accept handshake
//   wr_en/wr_addr/wr_data : instruction memory write port (byte address)
//   cpu_reset           : held high until a load succeeds
//   busy/done/error     : load status (done/error sticky)
// -----------------------------------------------------------------------------
module cargador_programa
    import cargador_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CW = ADDR_WIDTH + 1;

    // Where the FSM goes once all words are written (or N=0).
`ifdef CARGADOR_CHECKSUM_EN
    localparam state_e ST_AFTER_LAST = ST_CHK;
`else
    localparam state_e ST_AFTER_LAST = ST_DONE;
`endif

    state_e        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]   wr_addr_q, wr_addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic [15:0]   len_full;
    logic          accept;
    logic          pk_load, pk_clear, word_full;
    logic [31:0]   word;
`ifdef CARGADOR_CHECKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif

    assign byte_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign accept     = byte_valid && byte_ready;
    assign pk_load    = accept && (state_q == ST_DATA);
    assign pk_clear   = accept && (state_q == ST_LEN_HI);

    empaquetador_palabra u_empaquetador (
        .clk       (CLK),
        .srst      (Reset),
        .clear     (pk_clear),
        .load      (pk_load),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wr_addr_d   = wr_addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_reset_d = cpu_reset_q;
`ifdef CARGADOR_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        cnt_inc  = cnt_q + CW'(1);
        len_full = {byte_in, len_q[7:0]};

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d     = ST_LEN_LO;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cpu_reset_d = 1'b1;
`ifdef CARGADOR_CHECKSUM_EN
                    chk_d       = 8'd0;
`endif
                end else if (state_q == ST_DONE) begin
                    // Registered release: CPU leaves reset one cycle after DONE entry.
                    cpu_reset_d = 1'b0;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = byte_in;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = byte_in;
                    if (len_full == 16'd0) begin
                        state_d = ST_AFTER_LAST;
                    end else if ({1'b0, len_full} > len_max(ADDR_WIDTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d   = ST_DATA;
                        cnt_d     = '0;
                        wr_addr_d = BASE_ADDR;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
`ifdef CARGADOR_CHECKSUM_EN
                    chk_d = chk_q ^ byte_in;
`endif
                    if (word_full) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                cnt_d     = cnt_inc;
                wr_addr_d = wr_addr_q + 32'd4;
                if (17'(cnt_inc) == {1'b0, len_q}) begin
                    state_d = ST_AFTER_LAST;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHK: begin
`ifdef CARGADOR_CHECKSUM_EN
                if (accept) begin
                    state_d = (byte_in == chk_q) ? ST_DONE : ST_ERR;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Status flags change together with the terminal-state entry.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            busy_d  = 1'b0;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            len_q       <= 16'd0;
            cnt_q       <= '0;
            wr_addr_q   <= BASE_ADDR;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
`ifdef CARGADOR_CHECKSUM_EN
            chk_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
`ifdef CARGADOR_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign wr_en     = (state_q == ST_WRITE);
    assign wr_addr   = wr_addr_q;
    assign wr_data   = word;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
